// File: rtl/fifo_cascade_classic_to_axi_pkt_pkg.sv
// rtl/fifo_cascade_classic_to_axi_pkt_pkg.sv - shared FSM encodings and status width for the classic-to-AXI packet FIFO
package fifo_cascade_classic_to_axi_pkt_pkg;

    localparam int STAT_W = 16;

    typedef enum logic [0:0] {
        ST_GATE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_cascade_pkt_ram.sv
// rtl/fifo_cascade_pkt_ram.sv - simple dual-port RAM with registered read; the read register doubles as the output stage
module fifo_cascade_pkt_ram #(
    parameter int DW   = 33,
    parameter int SIZE = 9
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_en,
    input  logic [SIZE-1:0] wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic            rd_en,
    input  logic [SIZE-1:0] rd_addr,
    output logic [DW-1:0]   rd_data
);

    logic [DW-1:0] r_mem [0:(1<<SIZE)-1];
    logic [DW-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Holds its value when rd_en is low, which keeps the AXI outputs stable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
        end else if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/fifo_cascade_classic_to_axi_pkt.sv
// rtl/fifo_cascade_classic_to_axi_pkt.sv - src_rdy/dst_rdy to AXI-Stream FIFO with store-and-forward option; FIFO_CASCADE_STATUS_REG_EN registers status
module fifo_cascade_classic_to_axi_pkt
    import fifo_cascade_classic_to_axi_pkt_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SIZE     = 9,
    parameter bit PKT_MODE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [WIDTH-1:0]  datain,
    input  logic              eof_i,
    input  logic              src_rdy_i,
    output logic              dst_rdy_o,
    output logic [WIDTH-1:0]  tdata_o,
    output logic              tlast_o,
    output logic              tvalid_o,
    input  logic              tready_i,
    output logic [STAT_W-1:0] space,
    output logic [STAT_W-1:0] occupied,
    output logic [STAT_W-1:0] pkt_count,
    output logic              oversize_o
);

    localparam logic [STAT_W-1:0] CAP = STAT_W'(1 << SIZE);

    logic [SIZE-1:0]   r_wr_ptr, r_rd_ptr;
    logic [STAT_W-1:0] r_occ, r_pkt;
    logic              r_out_valid;
    logic              w_wr, w_hs, w_rd, w_ram_nempty, w_tvalid, w_oversize;
    logic [WIDTH:0]    w_rd_data;

    assign dst_rdy_o    = (r_occ != CAP);
    assign w_wr         = src_rdy_i && dst_rdy_o;
    assign w_hs         = w_tvalid && tready_i;
    assign w_ram_nempty = (r_occ != STAT_W'(r_out_valid));
    assign w_rd         = w_ram_nempty && (!r_out_valid || w_hs) && !clear;

    fifo_cascade_pkt_ram #(.DW(WIDTH + 1), .SIZE(SIZE)) u_ram (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_wr),
        .wr_addr (r_wr_ptr),
        .wr_data ({eof_i, datain}),
        .rd_en   (w_rd),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    assign tdata_o    = w_rd_data[WIDTH-1:0];
    assign tlast_o    = w_rd_data[WIDTH];
    assign tvalid_o   = w_tvalid;
    assign oversize_o = w_oversize;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_pkt       <= '0;
            r_out_valid <= 1'b0;
        end else if (clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_occ       <= '0;
            r_pkt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_occ       <= r_occ + STAT_W'(w_wr) - STAT_W'(w_hs);
            r_pkt       <= r_pkt + STAT_W'(w_wr && eof_i) - STAT_W'(w_hs && tlast_o);
            r_out_valid <= w_rd ? 1'b1 : (w_hs ? 1'b0 : r_out_valid);
        end
    end

    if (PKT_MODE) begin : g_pkt
        state_t r_state, w_state_nxt;
        logic   r_eof_wr;

        // A packet whose eof was written last cycle is not released yet, giving the same N+2 latency as the data path
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state  <= ST_GATE;
                r_eof_wr <= 1'b0;
            end else if (clear) begin
                r_state  <= ST_GATE;
                r_eof_wr <= 1'b0;
            end else begin
                r_state  <= w_state_nxt;
                r_eof_wr <= w_wr && eof_i;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            w_tvalid    = r_out_valid;
            w_oversize  = 1'b0;
            case (r_state)
                ST_GATE: begin
                    w_tvalid = r_out_valid && (r_pkt > STAT_W'(r_eof_wr));
                    if (r_occ == CAP && r_pkt == '0) begin
                        w_state_nxt = ST_FLUSH;
                        w_oversize  = 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (w_hs && tlast_o) w_state_nxt = ST_GATE;
                end
                default: w_state_nxt = ST_GATE;
            endcase
        end
    end else begin : g_stream
        assign w_tvalid   = r_out_valid;
        assign w_oversize = 1'b0;
    end

`ifdef FIFO_CASCADE_STATUS_REG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            space     <= CAP;
            occupied  <= '0;
            pkt_count <= '0;
        end else begin
            space     <= CAP - r_occ;
            occupied  <= r_occ;
            pkt_count <= r_pkt;
        end
    end
`else
    assign space     = CAP - r_occ;
    assign occupied  = r_occ;
    assign pkt_count = r_pkt;
`endif

endmodule

// File: tb/tb_fifo_cascade_classic_to_axi_pkt.sv
// tb/tb_fifo_cascade_classic_to_axi_pkt.sv - bench for stream and packet instances of the classic-to-AXI FIFO
module tb_fifo_cascade_classic_to_axi_pkt;

    logic        clk = 1'b0, reset = 1'b1, clear = 1'b0, sel = 1'b0;
    logic        src = 1'b0, eof = 1'b0, tready = 1'b0;
    logic [31:0] din = '0;

    logic        src_s, src_p, trdy_s, trdy_p;
    logic        s_dst, s_tlast, s_tvalid, s_ovs, p_dst, p_tlast, p_tvalid, p_ovs;
    logic [31:0] s_tdata, p_tdata;
    logic [15:0] s_space, s_occ, s_pkt, p_space, p_occ, p_pkt;

    logic        dst_rdy, tlast, tvalid, ovs;
    logic [31:0] tdata;
    logic [15:0] space, occ, pkt;

    int          n_checks = 0, n_fail = 0;
    logic [32:0] sb[$];

    always #5 clk = ~clk;

    assign src_s  = src && !sel;
    assign src_p  = src && sel;
    assign trdy_s = tready && !sel;
    assign trdy_p = tready && sel;

    fifo_cascade_classic_to_axi_pkt #(.WIDTH(32), .SIZE(4), .PKT_MODE(1'b0)) u_str (
        .clk(clk), .reset(reset), .clear(clear), .datain(din), .eof_i(eof), .src_rdy_i(src_s),
        .dst_rdy_o(s_dst), .tdata_o(s_tdata), .tlast_o(s_tlast), .tvalid_o(s_tvalid), .tready_i(trdy_s),
        .space(s_space), .occupied(s_occ), .pkt_count(s_pkt), .oversize_o(s_ovs));

    fifo_cascade_classic_to_axi_pkt #(.WIDTH(32), .SIZE(4), .PKT_MODE(1'b1)) u_pkt (
        .clk(clk), .reset(reset), .clear(clear), .datain(din), .eof_i(eof), .src_rdy_i(src_p),
        .dst_rdy_o(p_dst), .tdata_o(p_tdata), .tlast_o(p_tlast), .tvalid_o(p_tvalid), .tready_i(trdy_p),
        .space(p_space), .occupied(p_occ), .pkt_count(p_pkt), .oversize_o(p_ovs));

    assign dst_rdy = sel ? p_dst    : s_dst;
    assign tdata   = sel ? p_tdata  : s_tdata;
    assign tlast   = sel ? p_tlast  : s_tlast;
    assign tvalid  = sel ? p_tvalid : s_tvalid;
    assign ovs     = sel ? p_ovs    : s_ovs;
    assign space   = sel ? p_space  : s_space;
    assign occ     = sel ? p_occ    : s_occ;
    assign pkt     = sel ? p_pkt    : s_pkt;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Scoreboard bookkeeping for the cycle about to end, then advance one clock
    task automatic step();
        logic [32:0] e;
        if (reset || clear) begin
            sb.delete();
        end else begin
            if (tvalid && tready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_tdata", tdata, e[31:0]);
                    chk("sb_tlast", tlast, e[32]);
                end
            end
            if (src && dst_rdy) sb.push_back({eof, din});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic s);
        reset = 1'b1; clear = 1'b0; src = 1'b0; eof = 1'b0; tready = 1'b0; sel = s;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic drain();
        src = 1'b0; eof = 1'b0; tready = 1'b1;
        for (int c = 0; c < 60 && !(occ == 0 && !tvalid); c++) step();
        chk("drain_occ", occ, 0);
        chk("drain_sb_left", sb.size(), 0);
        tready = 1'b0;
    endtask

    typedef struct {
        bit          first;
        bit          sel;
        bit          src;
        bit          eof;
        logic [31:0] data;
        bit          tready;
        bit          exp_tvalid;
        int          exp_occ;
        int          exp_pkt;
    } vec_t;

    vec_t vecs[16];

    initial begin
        int nw, sent, ov_cnt, occ_ov, tl_cnt;
        bit flush_seen;

        // Stream: 5 words, sink always ready
        vecs[0]  = '{1, 0, 1, 0, 32'hA000, 1, 0, 0, 0};
        vecs[1]  = '{0, 0, 1, 0, 32'hA001, 1, 0, 1, 0};
        vecs[2]  = '{0, 0, 1, 0, 32'hA002, 1, 1, 2, 0};
        vecs[3]  = '{0, 0, 1, 0, 32'hA003, 1, 1, 2, 0};
        vecs[4]  = '{0, 0, 1, 0, 32'hA004, 1, 1, 2, 0};
        vecs[5]  = '{0, 0, 0, 0, 32'h0,    1, 1, 2, 0};
        vecs[6]  = '{0, 0, 0, 0, 32'h0,    1, 1, 1, 0};
        vecs[7]  = '{0, 0, 0, 0, 32'h0,    1, 0, 0, 0};
        // Packet: 3 words, eof on the third; release 2 cycles after it
        vecs[8]  = '{1, 1, 1, 0, 32'hB000, 1, 0, 0, 0};
        vecs[9]  = '{0, 1, 1, 0, 32'hB001, 1, 0, 1, 0};
        vecs[10] = '{0, 1, 1, 1, 32'hB002, 1, 0, 2, 0};
        vecs[11] = '{0, 1, 0, 0, 32'h0,    1, 0, 3, 1};
        vecs[12] = '{0, 1, 0, 0, 32'h0,    1, 1, 3, 1};
        vecs[13] = '{0, 1, 0, 0, 32'h0,    1, 1, 2, 1};
        vecs[14] = '{0, 1, 0, 0, 32'h0,    1, 1, 1, 1};
        vecs[15] = '{0, 1, 0, 0, 32'h0,    1, 0, 0, 0};

        do_reset(1'b0);
        chk("rst_s_occ", s_occ, 0);      chk("rst_s_space", s_space, 16);
        chk("rst_s_pkt", s_pkt, 0);      chk("rst_s_tvalid", s_tvalid, 0);
        chk("rst_s_tlast", s_tlast, 0);  chk("rst_s_tdata", s_tdata, 0);
        chk("rst_s_dst", s_dst, 1);      chk("rst_p_occ", p_occ, 0);
        chk("rst_p_space", p_space, 16); chk("rst_p_tvalid", p_tvalid, 0);
        chk("rst_p_ovs", p_ovs, 0);      chk("rst_p_dst", p_dst, 1);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].first) do_reset(vecs[i].sel);
            src = vecs[i].src; eof = vecs[i].eof; din = vecs[i].data; tready = vecs[i].tready;
            chk($sformatf("vec%0d_tvalid", i), tvalid, vecs[i].exp_tvalid);
            chk($sformatf("vec%0d_occ", i), occ, vecs[i].exp_occ);
            chk($sformatf("vec%0d_pkt", i), pkt, vecs[i].exp_pkt);
            step();
        end
        chk("vec_sb_left", sb.size(), 0);

        // Fill to capacity with the sink stalled, then one handshake
        do_reset(1'b0);
        nw = 0;
        for (int c = 0; c < 40 && dst_rdy; c++) begin
            src = 1'b1; din = 32'hC000 + c; nw++;
            step();
        end
        src = 1'b0;
        chk("fill_writes", nw, 16);
        chk("fill_occ", occ, 16);
        chk("fill_space", space, 0);
        chk("fill_dst_rdy", dst_rdy, 0);
        tready = 1'b1;
        step();
        tready = 1'b0;
        chk("fill_dst_rdy_after", dst_rdy, 1);
        chk("fill_occ_after", occ, 15);
        drain();

        // Oversized 20-word packet forces a cut-through flush
        do_reset(1'b1);
        sent = 0; ov_cnt = 0; occ_ov = -1; tl_cnt = 0; flush_seen = 0;
        tready = 1'b1;
        for (int c = 0; c < 200 && tl_cnt == 0; c++) begin
            src = (sent < 20); eof = (sent == 19); din = 32'hD000 + sent;
            if (ovs) begin ov_cnt++; occ_ov = occ; end
            if (tvalid && pkt == 0) flush_seen = 1'b1;
            if (tvalid && tready && tlast) tl_cnt++;
            if (src && dst_rdy) sent++;
            step();
        end
        src = 1'b0; eof = 1'b0;
        chk("ovs_pulses", ov_cnt, 1);
        chk("ovs_occ", occ_ov, 16);
        chk("ovs_flush_seen", flush_seen, 1);
        chk("ovs_sent", sent, 20);
        chk("ovs_tlast_cnt", tl_cnt, 1);
        chk("ovs_sb_left", sb.size(), 0);
        chk("ovs_occ_end", occ, 0);
        src = 1'b1; eof = 1'b0; din = 32'hD100;
        step();
        eof = 1'b1; din = 32'hD101;
        chk("gate_again_a1", tvalid, 0);
        step();
        src = 1'b0; eof = 1'b0;
        chk("gate_again_a2", tvalid, 0);
        step();
        chk("gate_again_a3", tvalid, 1);
        drain();

        // Simultaneous write and read at occupied=8, eof write with tlast read
        do_reset(1'b0);
        for (int c = 0; c < 8; c++) begin
            src = 1'b1; eof = (c == 0); din = 32'hE000 + c;
            step();
        end
        src = 1'b0; eof = 1'b0;
        step();
        chk("simul_occ_pre", occ, 8);
        chk("simul_pkt_pre", pkt, 1);
        chk("simul_tlast_pre", tlast, 1);
        src = 1'b1; eof = 1'b1; din = 32'hE0FF; tready = 1'b1;
        step();
        src = 1'b0; eof = 1'b0; tready = 1'b0;
        chk("simul_occ", occ, 8);
        chk("simul_pkt", pkt, 1);
        drain();
        chk("simul_pkt_end", pkt, 0);

        // clear with two packets held and a write pending
        do_reset(1'b1);
        for (int c = 0; c < 4; c++) begin
            src = 1'b1; eof = (c == 1 || c == 3); din = 32'hF000 + c;
            step();
        end
        src = 1'b0; eof = 1'b0;
        chk("clr_pkt_pre", pkt, 2);
        clear = 1'b1; src = 1'b1; din = 32'hF0AA;
        step();
        clear = 1'b0; src = 1'b0;
        chk("clr_occ", occ, 0);
        chk("clr_pkt", pkt, 0);
        chk("clr_tvalid", tvalid, 0);
        chk("clr_space", space, 16);

        // Reset in the middle of a packet discards it
        tready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            src = 1'b1; din = 32'hF100 + c;
            step();
        end
        src = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_occ", occ, 0);
        chk("mid_rst_pkt", pkt, 0);
        chk("mid_rst_tvalid", tvalid, 0);
        chk("mid_rst_tdata", tdata, 0);
        step();
        reset = 1'b0;
        src = 1'b1; eof = 1'b1; din = 32'hF1EE;
        step();
        src = 1'b0; eof = 1'b0;
        chk("single_n1_tvalid", tvalid, 0);
        step();
        chk("single_n2_tvalid", tvalid, 1);
        chk("single_n2_tlast", tlast, 1);
        drain();
        chk("single_pkt_end", pkt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
